debug_frame_tx: RTL and testbench
=================================

# debug_frame_tx

Serial transmitter for the seven 8-bit CPU debug ports, sitting directly downstream of the `cpu` top-level outputs `debug_port1`..`debug_port7`. On a trigger it snapshots all seven bytes and sends one framed packet over an 8N1 UART line to the host debugger: sync byte, seven payload bytes, then an XOR checksum. It gives the board a standalone way to stream per-step CPU state without an external logic analyser.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per UART bit (50 MHz / 115200); legal minimum 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `trigger`  in  1  request one frame; accepted only when `busy`=0.
- `debug_port1`..`debug_port7`  in  8 each  payload bytes, sampled on the accepting edge.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  high from the cycle after acceptance until the last stop bit completes.
- `frame_done`  out  1  one-cycle pulse in the cycle the last stop bit completes.

## Operation
- Frame is 9 bytes, in order: `SYNC_BYTE` (0xA5), port1..port7, checksum = port1^port2^…^port7 (sync excluded).
- Each byte is sent as start bit (0), 8 data bits LSB first, stop bit (1).
- Snapshot: on the edge where `trigger`=1 and `busy`=0, all seven ports are registered into a 7×8 holding register and the checksum is computed from the registered values. Port changes after that edge do not affect the frame.
- `trigger` while `busy`=1 is ignored. There is no queueing.
- Frame-level state: IDLE, SEND. A byte index counts 0..8.
- Byte-level FSM, inside the sub-module: IDLE → START → DATA (bit counter 0..7) → STOP → IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. Each counter wrap advances one bit.
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, all counters 0, state IDLE.
- Reset mid-frame: on the first edge with `nreset`=0, `tx` is 1 and the frame is abandoned. No partial checksum or stale byte is sent after release.

## Timing
- Acceptance at edge N: `busy`=1 and `tx`=0 (start bit of the sync byte) from cycle N+1.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- Bytes are back-to-back with no idle gap. Stop bit of byte k is followed immediately by start bit of byte k+1.
- Frame length: 90×CLKS_PER_BIT cycles from N+1.
- Completion cycle T = N+1+90×CLKS_PER_BIT: `frame_done`=1, `busy`=0, `tx`=1.
- Simultaneous event: `trigger` high in cycle T is accepted. The next start bit begins at T+1 with a fresh snapshot.

## Structure
- Shared package `debug_pkg`:
  - `SYNC_BYTE`=8'hA5
  - `FRAME_BYTES`=9
  - `PAYLOAD_BYTES`=7
  - byte-FSM state encodings
- Sub-module `uart_byte_tx`:
  - inputs: `clk`, `nreset`, `start`, `data[7:0]`
  - outputs: `tx`, `ready`, `byte_done`
  - parameter: `CLKS_PER_BIT`
- The top level owns the snapshot register, byte index, checksum and the mux feeding `data`.

## Test plan
- Reset idle: hold `nreset`=0 for 3 cycles, then release → `tx`=1, `busy`=0, `frame_done`=0 until the first trigger.
- Basic frame: CLKS_PER_BIT=4; ports 0x01,0x00,0x00,0x00,0x00,0x00,0x80; pulse `trigger` → decoded bytes A5,01,00,00,00,00,00,80,81.
  - `frame_done` pulses exactly 360 cycles after `busy` rises.
- Snapshot isolation: change all ports to 0xFF one cycle after acceptance → frame still carries the original bytes and checksum 0x81.
- Busy ignore: pulse `trigger` mid-frame → no effect on the bit stream; exactly one `frame_done` pulse.
- Back-to-back: hold `trigger`=1 continuously → second frame's start bit at T+1, with no idle bit between frames.
- Reset mid-frame: assert `nreset`=0 during the byte-4 data bits → `tx`=1 and `busy`=0 on the next edge; a new trigger after release yields a clean full frame.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants, state encodings and the payload checksum helper for the
// debug-port frame transmitter.
package debug_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         FRAME_BYTES   = 9;
  localparam int         PAYLOAD_BYTES = 7;

  // Byte-level serialiser states
  typedef enum logic [1:0] {
    BYTE_IDLE  = 2'd0,
    BYTE_START = 2'd1,
    BYTE_DATA  = 2'd2,
    BYTE_STOP  = 2'd3
  } byte_state_t;

  // Frame-level states
  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_SEND = 1'b1
  } frame_state_t;

  // XOR of all payload bytes; byte 0 of the bus is port1
  function automatic logic [7:0] payload_checksum(input logic [PAYLOAD_BYTES*8-1:0] payload);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      acc = acc ^ payload[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A new byte may be loaded while idle or in the last
// cycle of a stop bit, which lets the caller chain bytes with no idle gap.
module uart_byte_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  byte_state_t   state_reg;
  logic [CW-1:0] baud_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          byte_done_reg;
  logic          baud_wrap;

  assign baud_wrap = (baud_reg == BAUD_LAST);
  // Ready to accept: idle, or about to leave the stop bit
  assign ready     = (state_reg == BYTE_IDLE) || ((state_reg == BYTE_STOP) && baud_wrap);
  assign tx        = tx_reg;
  assign byte_done = byte_done_reg;

  // Byte FSM with registered line output and bit timing
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg     <= BYTE_IDLE;
      baud_reg      <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= 1'b1;
      byte_done_reg <= 1'b0;
    end else begin
      byte_done_reg <= 1'b0;
      case (state_reg)
        BYTE_IDLE: begin
          baud_reg <= '0;
          tx_reg   <= 1'b1;
          if (start) begin
            state_reg <= BYTE_START;
            shift_reg <= data;
            tx_reg    <= 1'b0;
          end
        end
        BYTE_START: begin
          if (baud_wrap) begin
            baud_reg    <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= BYTE_DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        BYTE_DATA: begin
          if (baud_wrap) begin
            baud_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= BYTE_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        BYTE_STOP: begin
          if (baud_wrap) begin
            baud_reg      <= '0;
            bit_cnt_reg   <= '0;
            byte_done_reg <= 1'b1;
            if (start) begin
              state_reg <= BYTE_START;
              shift_reg <= data;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= BYTE_IDLE;
              tx_reg    <= 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= BYTE_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Snapshots the seven CPU debug ports on a trigger and streams them as one
// framed packet: sync byte, seven payload bytes, XOR checksum.
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  frame_state_t               frame_state_reg;
  logic [3:0]                 byte_idx_reg;
  logic [PAYLOAD_BYTES*8-1:0] snap_reg;
  logic [PAYLOAD_BYTES*8-1:0] port_bus;
  logic [7:0]                 frame_bytes [FRAME_BYTES];
  logic [7:0]                 checksum;
  logic [7:0]                 byte_data;
  logic [3:0]                 next_idx;
  logic                       accept;
  logic                       last_byte;
  logic                       byte_start;
  logic                       byte_ready;
  logic                       byte_done;

  assign port_bus  = {debug_port7, debug_port6, debug_port5, debug_port4,
                      debug_port3, debug_port2, debug_port1};
  assign accept    = trigger && (frame_state_reg == FRAME_IDLE);
  assign checksum  = payload_checksum(snap_reg);
  assign last_byte = (byte_idx_reg == 4'(FRAME_BYTES - 1));
  assign next_idx  = byte_idx_reg + 4'd1;

  // Frame byte table built from the snapshot
  assign frame_bytes[0]               = SYNC_BYTE;
  assign frame_bytes[FRAME_BYTES - 1] = checksum;
  generate
    for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
      assign frame_bytes[gi + 1] = snap_reg[gi*8 +: 8];
    end
  endgenerate

  // Byte feed: sync on acceptance, otherwise the next byte as the current stop bit ends
  always_comb begin
    byte_data  = SYNC_BYTE;
    byte_start = 1'b0;
    if (accept) begin
      byte_start = 1'b1;
    end else if ((frame_state_reg == FRAME_SEND) && byte_ready && !last_byte) begin
      byte_start = 1'b1;
      byte_data  = frame_bytes[next_idx];
    end
  end

  // Frame FSM: snapshot on acceptance, step the byte index at each byte boundary
  always_ff @(posedge clk) begin
    if (!nreset) begin
      frame_state_reg <= FRAME_IDLE;
      byte_idx_reg    <= '0;
      snap_reg        <= '0;
    end else begin
      case (frame_state_reg)
        FRAME_IDLE: begin
          if (accept) begin
            snap_reg        <= port_bus;
            byte_idx_reg    <= '0;
            frame_state_reg <= FRAME_SEND;
          end
        end
        FRAME_SEND: begin
          if (byte_ready) begin
            if (last_byte) begin
              byte_idx_reg    <= '0;
              frame_state_reg <= FRAME_IDLE;
            end else begin
              byte_idx_reg <= next_idx;
            end
          end
        end
        default: frame_state_reg <= FRAME_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .nreset    (nreset),
    .start     (byte_start),
    .data      (byte_data),
    .tx        (tx),
    .ready     (byte_ready),
    .byte_done (byte_done)
  );

  assign busy = (frame_state_reg == FRAME_SEND);
  // The last byte's completion pulse lands in the cycle the frame FSM is back in idle
  assign frame_done = byte_done && (frame_state_reg == FRAME_IDLE);

endmodule

// File: tb/tb_debug_frame_tx.sv
// Scoreboard bench: stimulus pushes the expected frame bytes, a UART decoder
// pops and compares, and a timing monitor checks busy/frame_done behaviour.
module tb_debug_frame_tx;

  localparam int C            = 4;
  localparam int FRAME_CYCLES = 90 * C;

  logic       clk = 1'b0;
  logic       nreset;
  logic       trigger;
  logic [7:0] p [1:7];
  logic       tx, busy, frame_done;

  typedef struct {
    logic [7:0] b;
    int         pos;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   frames_expected = 0;
  int   done_count = 0;

  debug_frame_tx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .trigger     (trigger),
    .debug_port1 (p[1]),
    .debug_port2 (p[2]),
    .debug_port3 (p[3]),
    .debug_port4 (p[4]),
    .debug_port5 (p[5]),
    .debug_port6 (p[6]),
    .debug_port7 (p[7]),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is sync, the seven ports, then their XOR
  task automatic push_frame(input logic [7:0] v [1:7]);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back('{8'hA5, 0});
    for (int i = 1; i <= 7; i++) begin
      exp_q.push_back('{v[i], i});
      x = x ^ v[i];
    end
    exp_q.push_back('{x, 8});
    frames_expected++;
  endtask

  task automatic set_ports(input logic [7:0] v [1:7]);
    for (int i = 1; i <= 7; i++) p[i] = v[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with busy low; acceptance is the next edge
  task automatic fire(input logic [7:0] v [1:7]);
    set_ports(v);
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    push_frame(v);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < FRAME_CYCLES + 50; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic rand_ports(output logic [7:0] v [1:7]);
    for (int i = 1; i <= 7; i++) v[i] = 8'($urandom);
  endtask

  // UART decoder / scoreboard consumer
  initial begin : byte_monitor
    int         s;
    int         last_end;
    logic [9:0] bits;
    bit         glitch;
    bit         aborted;
    exp_t       e;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (nreset === 1'b1 && tx === 1'b0) begin
        s       = cyc;
        glitch  = 1'b0;
        aborted = 1'b0;
        bits    = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int j = 0; j < C && !aborted; j++) begin
            if (b != 0 || j != 0) begin
              @(negedge clk);
              if (nreset !== 1'b1) aborted = 1'b1;
            end
            if (!aborted) begin
              if (j == 0) bits[b] = tx;
              else if (tx !== bits[b]) glitch = 1'b1;
            end
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("byte pos %0d: got %02h expected %02h at cycle %0d", e.pos, bits[8:1], e.b, s);
            check($sformatf("byte_pos%0d", e.pos), {24'd0, bits[8:1]}, {24'd0, e.b});
            check("stop_bit", {31'd0, bits[9]}, 32'd1);
            check("bit_stable", {31'd0, glitch}, 32'd0);
            if (e.pos != 0) check("byte_gap", s, last_end + 1);
          end
          last_end = cyc;
        end
      end
    end
  end

  // busy / frame_done timing monitor
  initial begin : timing_monitor
    int rise_cyc;
    bit rise_valid;
    bit busy_prev;
    rise_cyc   = 0;
    rise_valid = 1'b0;
    busy_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (nreset !== 1'b1) begin
        rise_valid = 1'b0;
        busy_prev  = 1'b0;
      end else begin
        if (busy === 1'b1 && !busy_prev) begin
          rise_cyc   = cyc;
          rise_valid = 1'b1;
          check("start_bit_with_busy", {31'd0, tx}, 32'd0);
        end
        if (frame_done === 1'b1) begin
          done_count++;
          check("done_busy_low", {31'd0, busy}, 32'd0);
          check("done_tx_high", {31'd0, tx}, 32'd1);
          check("done_after_busy", {31'd0, rise_valid}, 32'd1);
          check("done_latency", cyc - rise_cyc, FRAME_CYCLES);
          rise_valid = 1'b0;
        end
        busy_prev = (busy === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] v  [1:7];
    logic [7:0] v2 [1:7];
    logic [7:0] ff [1:7];
    nreset  = 1'b0;
    trigger = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      p[i]  = 8'h00;
      ff[i] = 8'hFF;
    end

    // Reset idle
    repeat (3) tick();
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_tx", {31'd0, tx}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, frame_done}, 32'd0);
    end

    // Basic frame
    tick();
    v = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    fire(v);
    wait_done("basic");

    // Snapshot isolation: ports change one cycle after acceptance
    tick();
    fire(v);
    set_ports(ff);
    wait_done("snapshot");

    // Trigger while busy is ignored
    tick();
    rand_ports(v);
    fire(v);
    repeat (150) tick();
    rand_ports(v2);
    set_ports(v2);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_done("busy_ignore");
    repeat (30) tick();
    check("ignored_no_frame", {31'd0, busy}, 32'd0);

    // Back-to-back with trigger held
    rand_ports(v);
    rand_ports(v2);
    set_ports(v);
    trigger = 1'b1;
    @(posedge clk);
    #1;
    push_frame(v);
    set_ports(v2);
    push_frame(v2);
    wait_done("b2b_first");
    @(negedge clk);
    check("b2b_start_tx", {31'd0, tx}, 32'd0);
    check("b2b_start_busy", {31'd0, busy}, 32'd1);
    trigger = 1'b0;
    wait_done("b2b_second");

    // Reset during byte 4 data bits
    tick();
    rand_ports(v);
    fire(v);
    repeat (43 * C) tick();
    nreset = 1'b0;
    exp_q.delete();
    frames_expected--;
    @(posedge clk);
    @(negedge clk);
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_tx", {31'd0, tx}, 32'd1);
    end
    tick();
    rand_ports(v);
    fire(v);
    wait_done("post_reset");

    // Random frames with random idle gaps
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 20)) tick();
      rand_ports(v);
      fire(v);
      wait_done("random");
    end

    repeat (20) tick();
    check("queue_drained", exp_q.size(), 0);
    check("frame_count", done_count, frames_expected);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
